// File: rtl/bus_pkg.sv
// Shared bus arbitration types and default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bus_pkg;

  localparam int BUS_WIDTH_DEF  = 32;
  localparam int CTRL_WIDTH_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

  // Tenure counter must hold 0..MAX_HOLD-1; keep at least one bit so the vector is legal.
  function automatic int cnt_width(input int max_hold);
    return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority encoder: first set req bit above last_owner, wrapping.
// Latency: combinational.
// Backpressure: none; caller decides when winner is consumed.
module rr_pick #(
  parameter int N    = 8,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last_owner,
  output logic [ID_W-1:0] winner,
  output logic            any
);

  // last_owner < N and offset <= N, so one conditional subtract replaces a modulo.
  function automatic logic [ID_W-1:0] wrap_idx(input int sum);
    int s;
    s = (sum >= N) ? sum - N : sum;
    return s[ID_W-1:0];
  endfunction

  // Scan from the farthest candidate down so the nearest requester overwrites last.
  always_comb begin
    winner = '0;
    any    = |req;
    for (int i = N; i >= 1; i--) begin
      if (req[wrap_idx(int'(last_owner) + i)]) begin
        winner = wrap_idx(int'(last_owner) + i);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with optional tenure limit, plus shared data/control mux.
// Latency: grant one edge after req sampled in IDLE; one IDLE turnaround between tenures.
// Backpressure: level req held by owner; non-owner requests wait until the bus goes IDLE.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int N_MASTERS  = 8,
  parameter int BUS_WIDTH  = BUS_WIDTH_DEF,
  parameter int CTRL_WIDTH = CTRL_WIDTH_DEF,
  parameter int MAX_HOLD   = 0,
  parameter int ID_W       = $clog2(N_MASTERS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [N_MASTERS-1:0]             req,
  input  logic [N_MASTERS*BUS_WIDTH-1:0]   bus_in,
  input  logic [N_MASTERS*CTRL_WIDTH-1:0]  ctrl_in,
  output logic [N_MASTERS-1:0]             ack,
  output logic [BUS_WIDTH-1:0]             bus_out,
  output logic [CTRL_WIDTH-1:0]            ctrl_out,
  output logic [ID_W-1:0]                  grant_id,
  output logic                             busy
);

  arb_state_t            state_q, state_d;
  logic [N_MASTERS-1:0]  ack_d;
  logic [ID_W-1:0]       grant_d;
  logic [ID_W-1:0]       last_q, last_d;
  logic [ID_W-1:0]       pick_id;
  logic                  pick_any;
  logic                  grant_start;
  logic                  preempt;

  rr_pick #(
    .N    (N_MASTERS),
    .ID_W (ID_W)
  ) u_pick (
    .req        (req),
    .last_owner (last_q),
    .winner     (pick_id),
    .any        (pick_any)
  );

  assign busy        = (state_q == OWNED);
  assign grant_start = (state_q == IDLE) && pick_any;

  generate
    if (MAX_HOLD > 0) begin : g_tenure
      localparam int              CNT_W    = cnt_width(MAX_HOLD);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

      logic [CNT_W-1:0] tenure_q;
      logic             others_req;

      // ack is the owner's one-hot, so masking with it leaves only waiters.
      assign others_req = |(req & ~ack);
      assign preempt    = busy && (tenure_q == CNT_LAST) && others_req;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          tenure_q <= '0;
        end else if (grant_start) begin
          tenure_q <= '0;
        end else if (busy && (tenure_q != CNT_LAST)) begin
          tenure_q <= tenure_q + 1'b1;
        end
      end
    end else begin : g_no_tenure
      assign preempt = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    ack_d   = ack;
    grant_d = grant_id;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d        = OWNED;
          ack_d          = '0;
          ack_d[pick_id] = 1'b1;
          grant_d        = pick_id;
        end
      end
      OWNED: begin
        // Release and preemption share one path: the owner becomes lowest priority.
        if (!req[grant_id] || preempt) begin
          state_d = IDLE;
          ack_d   = '0;
          last_d  = grant_id;
        end
      end
      default: begin
        state_d = IDLE;
        ack_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ack      <= '0;
      grant_id <= '0;
      last_q   <= ID_W'(N_MASTERS - 1);
    end else begin
      state_q  <= state_d;
      ack      <= ack_d;
      grant_id <= grant_d;
      last_q   <= last_d;
    end
  end

  always_comb begin
    bus_out  = '0;
    ctrl_out = '0;
    if (busy) begin
      for (int i = 0; i < N_MASTERS; i++) begin
        if (grant_id == ID_W'(i)) begin
          bus_out  = bus_in[i*BUS_WIDTH +: BUS_WIDTH];
          ctrl_out = ctrl_in[i*CTRL_WIDTH +: CTRL_WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: two instances (unlimited tenure and MAX_HOLD=4) share stimulus.
// Latency: n/a. Backpressure: n/a.
// Expected values come from scripted constants and a cycle-level reference model.
module tb_bus_arbiter;

  localparam int N  = 8;
  localparam int BW = 32;
  localparam int CW = 8;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req   = '0;
  logic [N*BW-1:0] bus_in  = '0;
  logic [N*CW-1:0] ctrl_in = '0;

  logic [N-1:0]  ack_o  [2];
  logic [BW-1:0] bus_o  [2];
  logic [CW-1:0] ctrl_o [2];
  logic [2:0]    gid_o  [2];
  logic          busy_o [2];

  int checks = 0;
  int passes = 0;

  // Reference model: owner (-1 = none), previous owner, cycles of ack already high.
  int m_owner [2] = '{-1, -1};
  int m_last  [2] = '{7, 7};
  int m_ten   [2] = '{0, 0};

  bus_arbiter #(.N_MASTERS(N), .BUS_WIDTH(BW), .CTRL_WIDTH(CW), .MAX_HOLD(0)) dut0 (
    .clk(clk), .reset(rst_n), .req(req), .bus_in(bus_in), .ctrl_in(ctrl_in),
    .ack(ack_o[0]), .bus_out(bus_o[0]), .ctrl_out(ctrl_o[0]), .grant_id(gid_o[0]), .busy(busy_o[0])
  );

  bus_arbiter #(.N_MASTERS(N), .BUS_WIDTH(BW), .CTRL_WIDTH(CW), .MAX_HOLD(4)) dut4 (
    .clk(clk), .reset(rst_n), .req(req), .bus_in(bus_in), .ctrl_in(ctrl_in),
    .ack(ack_o[1]), .bus_out(bus_o[1]), .ctrl_out(ctrl_o[1]), .grant_id(gid_o[1]), .busy(busy_o[1])
  );

  always #5 clk = ~clk;

  function automatic int hold_of(input int d);
    return (d == 0) ? 0 : 4;
  endfunction

  function automatic int rr_next(input logic [7:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [7:0] exp_ack(input int d);
    return (m_owner[d] >= 0) ? (8'd1 << m_owner[d]) : 8'd0;
  endfunction

  function automatic logic [BW-1:0] exp_bus(input int d);
    return (m_owner[d] >= 0) ? bus_in[m_owner[d]*BW +: BW] : '0;
  endfunction

  function automatic logic [CW-1:0] exp_ctrl(input int d);
    return (m_owner[d] >= 0) ? ctrl_in[m_owner[d]*CW +: CW] : '0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_owner[d] <= -1;
        m_last[d]  <= N - 1;
        m_ten[d]   <= 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (m_owner[d] < 0) begin
          if (rr_next(req, m_last[d]) >= 0) begin
            m_owner[d] <= rr_next(req, m_last[d]);
            m_ten[d]   <= 1;
          end
        end else if (!req[m_owner[d]] ||
                     (hold_of(d) > 0 && m_ten[d] >= hold_of(d) &&
                      (req & ~(8'd1 << m_owner[d])) != 8'd0)) begin
          m_last[d]  <= m_owner[d];
          m_owner[d] <= -1;
        end else begin
          m_ten[d] <= m_ten[d] + 1;
        end
      end
    end
  end

  task automatic do_reset(input logic [7:0] r);
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    req   = r;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 8'($urandom);
    for (int m = 0; m < N; m++) begin
      bus_in[m*BW +: BW]  = $urandom;
      ctrl_in[m*CW +: CW] = 8'($urandom);
    end
    repeat (2) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        checks++; if (ack_o[d] !== 8'h00) $display("FAIL reset_ack[%0d]: got %h expected 00", d, ack_o[d]); else passes++;
        checks++; if (busy_o[d] !== 1'b0) $display("FAIL reset_busy[%0d]: got %b expected 0", d, busy_o[d]); else passes++;
        checks++; if (gid_o[d] !== 3'd0) $display("FAIL reset_gid[%0d]: got %0d expected 0", d, gid_o[d]); else passes++;
        checks++; if (bus_o[d] !== '0) $display("FAIL reset_bus[%0d]: got %h expected 0", d, bus_o[d]); else passes++;
        checks++; if (ctrl_o[d] !== '0) $display("FAIL reset_ctrl[%0d]: got %h expected 0", d, ctrl_o[d]); else passes++;
      end
    end
    @(negedge clk);
    req   = 8'h81;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (ack_o[d] !== 8'h01) $display("FAIL first_grant_ack[%0d]: got %h expected 01", d, ack_o[d]); else passes++;
      checks++; if (bus_o[d] !== bus_in[BW-1:0]) $display("FAIL first_grant_bus[%0d]: got %h expected %h", d, bus_o[d], bus_in[BW-1:0]); else passes++;
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] want;
    int g;
    do_reset(8'hFF);
    for (int t = 0; t < 36; t++) begin
      @(posedge clk); #1;
      g    = (t / 4) % N;
      want = ((t % 4) < 3) ? (8'd1 << g) : 8'd0;
      checks++; if (ack_o[0] !== want) $display("FAIL rr_ack t=%0d: got %h expected %h", t, ack_o[0], want); else passes++;
      checks++; if (ack_o[0] !== exp_ack(0)) $display("FAIL rr_model t=%0d: got %h expected %h", t, ack_o[0], exp_ack(0)); else passes++;
      @(negedge clk);
      req = 8'hFF;
      if (m_owner[0] >= 0 && m_ten[0] == 3) req[m_owner[0]] = 1'b0;
    end
  endtask

  task automatic test_preempt();
    logic [7:0] want;
    int g;
    do_reset(8'h24);
    for (int t = 0; t < 15; t++) begin
      @(posedge clk); #1;
      g    = ((t / 5) % 2 == 0) ? 2 : 5;
      want = ((t % 5) < 4) ? (8'd1 << g) : 8'd0;
      checks++; if (ack_o[1] !== want) $display("FAIL preempt_ack t=%0d: got %h expected %h", t, ack_o[1], want); else passes++;
      checks++; if (ack_o[0] !== 8'h04) $display("FAIL nolimit_hold t=%0d: got %h expected 04", t, ack_o[0]); else passes++;
    end
  endtask

  task automatic test_no_waiters();
    do_reset(8'h08);
    for (int t = 0; t < 20; t++) begin
      @(posedge clk); #1;
      checks++; if (ack_o[1] !== 8'h08) $display("FAIL solo_ack t=%0d: got %h expected 08", t, ack_o[1]); else passes++;
    end
  endtask

  task automatic test_mux();
    for (int m = 0; m < N; m++) begin
      bus_in[m*BW +: BW]  = $urandom;
      ctrl_in[m*CW +: CW] = 8'($urandom);
    end
    bus_in[6*BW +: BW]  = 32'hDEADBEEF;
    ctrl_in[6*CW +: CW] = 8'hA5;
    do_reset(8'h40);
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (gid_o[d] !== 3'd6) $display("FAIL mux_gid[%0d]: got %0d expected 6", d, gid_o[d]); else passes++;
      checks++; if (bus_o[d] !== 32'hDEADBEEF) $display("FAIL mux_bus[%0d]: got %h expected deadbeef", d, bus_o[d]); else passes++;
      checks++; if (ctrl_o[d] !== 8'hA5) $display("FAIL mux_ctrl[%0d]: got %h expected a5", d, ctrl_o[d]); else passes++;
    end
    @(negedge clk);
    req = 8'h00;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (bus_o[d] !== '0) $display("FAIL idle_bus[%0d]: got %h expected 0", d, bus_o[d]); else passes++;
      checks++; if (ctrl_o[d] !== '0) $display("FAIL idle_ctrl[%0d]: got %h expected 0", d, ctrl_o[d]); else passes++;
    end
  endtask

  task automatic test_async_reset();
    do_reset(8'h10);
    repeat (2) @(posedge clk);
    @(posedge clk); #1;
    checks++; if (ack_o[1] !== 8'h10) $display("FAIL pre_reset_ack: got %h expected 10", ack_o[1]); else passes++;
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (ack_o[d] !== 8'h00) $display("FAIL async_ack[%0d]: got %h expected 00", d, ack_o[d]); else passes++;
      checks++; if (busy_o[d] !== 1'b0) $display("FAIL async_busy[%0d]: got %b expected 0", d, busy_o[d]); else passes++;
      checks++; if (bus_o[d] !== '0) $display("FAIL async_bus[%0d]: got %h expected 0", d, bus_o[d]); else passes++;
    end
    @(negedge clk);
    @(negedge clk);
    req   = 8'hFF;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (ack_o[d] !== 8'h01) $display("FAIL post_reset_ack[%0d]: got %h expected 01", d, ack_o[d]); else passes++;
    end
  endtask

  task automatic test_random();
    do_reset(8'($urandom));
    for (int t = 0; t < 500; t++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        checks++; if (ack_o[d] !== exp_ack(d)) $display("FAIL rand_ack[%0d] t=%0d: got %h expected %h", d, t, ack_o[d], exp_ack(d)); else passes++;
        checks++; if (busy_o[d] !== (m_owner[d] >= 0)) $display("FAIL rand_busy[%0d] t=%0d: got %b expected %b", d, t, busy_o[d], m_owner[d] >= 0); else passes++;
        if (m_owner[d] >= 0) begin
          checks++; if (gid_o[d] !== 3'(m_owner[d])) $display("FAIL rand_gid[%0d] t=%0d: got %0d expected %0d", d, t, gid_o[d], m_owner[d]); else passes++;
        end
        checks++; if (bus_o[d] !== exp_bus(d)) $display("FAIL rand_bus[%0d] t=%0d: got %h expected %h", d, t, bus_o[d], exp_bus(d)); else passes++;
        checks++; if (ctrl_o[d] !== exp_ctrl(d)) $display("FAIL rand_ctrl[%0d] t=%0d: got %h expected %h", d, t, ctrl_o[d], exp_ctrl(d)); else passes++;
      end
      @(negedge clk);
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(9) == 0) req[b] = ~req[b];
      end
      for (int m = 0; m < N; m++) begin
        bus_in[m*BW +: BW]  = $urandom;
        ctrl_in[m*CW +: CW] = 8'($urandom);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_preempt();
    test_no_waiters();
    test_mux();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
